// File: rtl/dr32e_multdiv_iter.sv
// dr32e_multdiv_iter
// Iterative RV32M multiply/divide unit sitting beside the execute-stage ALU.
// MUL/MULH use a 32-step shift-and-add on operand magnitudes; DIV/REM use a
// 32-step restoring division. Signs are applied once at the end.
//
// Handshake: the issuer raises en_i with operands and holds it (and the
// operands are don't-care after the start cycle) until valid_o pulses for one
// cycle. Dropping en_i while busy_o is high aborts the operation with no
// valid_o and result_o left untouched.
//
// Parameters:
//   DivZeroFast  1: DIV/REM by zero finishes straight from IDLE (valid_o in
//                cycle 1); 0: it runs the full 32 iterations, same result.
// Optional build macro:
//   DR32E_MULT_EARLY_EXIT_EN  multiply leaves CALC as soon as the remaining
//                multiplier magnitude is zero (valid_o as early as cycle 2).
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   en_i                 operation request (held until valid_o)
//   md_op_i[1:0]         0=MUL, 1=MULH, 2=DIV, 3=REM
//   signed_a_i/_b_i      operand A/B treated as signed
//   operand_a_i/_b_i     multiplicand/dividend, multiplier/divisor
//   busy_o               operation in progress (pipeline stall)
//   valid_o              result_o valid, single-cycle pulse
//   result_o             registered result
//   state_o[1:0]         FSM state for observation (0=IDLE,1=CALC,2=FINISH)
module dr32e_multdiv_iter #(
    parameter bit DivZeroFast = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [1:0]  md_op_i,
    input  logic        signed_a_i,
    input  logic        signed_b_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_REM  = 2'd3;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic        res_neg_q;
    logic [63:0] acc_q, mcand_q;
    logic [31:0] mplier_q, divisor_q, rem_q, quo_q;
    logic [31:0] result_q, result_d;
    logic        load, step;

    // ---------------- start-of-operation values ----------------
    logic        neg_a, neg_b, b_zero, res_neg_start;
    logic [31:0] mag_a, mag_b;

    assign neg_a  = signed_a_i & operand_a_i[31];
    assign neg_b  = signed_b_i & operand_b_i[31];
    assign mag_a  = neg_a ? (32'd0 - operand_a_i) : operand_a_i;
    assign mag_b  = neg_b ? (32'd0 - operand_b_i) : operand_b_i;
    assign b_zero = (operand_b_i == 32'd0);

    always_comb begin
        res_neg_start = 1'b0;
        case (md_op_i)
            OP_MUL, OP_MULH: res_neg_start = neg_a ^ neg_b;
            OP_DIV:          res_neg_start = (neg_a ^ neg_b) & ~b_zero;
            OP_REM:          res_neg_start = neg_a;
            default:         res_neg_start = 1'b0;
        endcase
    end

    // ---------------- one iteration ----------------
    // Multiply: the multiplicand moves left, so the accumulator is always in
    // final alignment and an early exit needs no extra shift.
    logic [63:0] acc_nx, mcand_nx;
    logic [31:0] mplier_nx;
    assign acc_nx    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mcand_nx  = {mcand_q[62:0], 1'b0};
    assign mplier_nx = {1'b0, mplier_q[31:1]};

    // Divide: quo_q starts as the dividend magnitude and is shifted out MSB
    // first into the 33-bit partial remainder while quotient bits shift in.
    // Bit 32 of the difference is its sign because rem_sh < 2*divisor.
    logic [32:0] rem_sh, diff;
    logic        q_bit;
    logic [31:0] rem_nx, quo_nx;
    assign rem_sh = {rem_q, quo_q[31]};
    assign diff   = rem_sh - {1'b0, divisor_q};
    assign q_bit  = ~diff[32];
    assign rem_nx = q_bit ? diff[31:0] : rem_sh[31:0];
    assign quo_nx = {quo_q[30:0], q_bit};

    // Final sign fix-up applied to the values produced by the last iteration.
    logic [63:0] prod_fin;
    logic [31:0] final_res;
    assign prod_fin = res_neg_q ? (64'd0 - acc_nx) : acc_nx;
    always_comb begin
        final_res = 32'd0;
        case (op_q)
            OP_MUL:  final_res = prod_fin[31:0];
            OP_MULH: final_res = prod_fin[63:32];
            OP_DIV:  final_res = res_neg_q ? (32'd0 - quo_nx) : quo_nx;
            OP_REM:  final_res = res_neg_q ? (32'd0 - rem_nx) : rem_nx;
            default: final_res = 32'd0;
        endcase
    end

    logic early_exit;
`ifdef DR32E_MULT_EARLY_EXIT_EN
    assign early_exit = ~op_q[1] & (mplier_nx == 32'd0);
`else
    assign early_exit = 1'b0;
`endif

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    load = 1'b1;
                    if (DivZeroFast && md_op_i[1] && b_zero) begin
                        // Quotient of all ones; remainder is the dividend.
                        state_d  = FINISH;
                        result_d = (md_op_i == OP_DIV) ? 32'hFFFF_FFFF : operand_a_i;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == 5'd31 || early_exit) begin
                        state_d  = FINISH;
                        result_d = final_res;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 2'd0;
            res_neg_q <= 1'b0;
            acc_q     <= 64'd0;
            mcand_q   <= 64'd0;
            mplier_q  <= 32'd0;
            divisor_q <= 32'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            result_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (load) begin
                cnt_q     <= 5'd0;
                op_q      <= md_op_i;
                res_neg_q <= res_neg_start;
                acc_q     <= 64'd0;
                mcand_q   <= {32'd0, mag_a};
                mplier_q  <= mag_b;
                divisor_q <= mag_b;
                rem_q     <= 32'd0;
                quo_q     <= mag_a;
            end else if (step) begin
                cnt_q    <= cnt_q + 5'd1;
                acc_q    <= acc_nx;
                mcand_q  <= mcand_nx;
                mplier_q <= mplier_nx;
                rem_q    <= rem_nx;
                quo_q    <= quo_nx;
            end
        end
    end

    assign busy_o   = (state_q == CALC);
    assign valid_o  = (state_q == FINISH);
    assign result_o = result_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_dr32e_multdiv_iter.sv
module tb_dr32e_multdiv_iter;

  localparam bit DZF = 1'b1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic [1:0]  md_op_i = 2'd0;
  logic        signed_a_i = 1'b0;
  logic        signed_b_i = 1'b0;
  logic [31:0] operand_a_i = 32'd0;
  logic [31:0] operand_b_i = 32'd0;
  logic        busy_o, valid_o;
  logic [31:0] result_o;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  dr32e_multdiv_iter #(.DivZeroFast(DZF)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .md_op_i(md_op_i),
    .signed_a_i(signed_a_i), .signed_b_i(signed_b_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o), .state_o(state_o)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'd0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic sa, input logic sb,
                                             input logic [31:0] a, input logic [31:0] b);
    longint x, y, p;
    x = sa ? longint'($signed(a)) : longint'(a);
    y = sb ? longint'($signed(b)) : longint'(b);
    p = 0;
    case (op)
      2'd0: begin p = x * y; return p[31:0]; end
      2'd1: begin p = x * y; return p[63:32]; end
      2'd2: begin if (b == 0) return 32'hFFFF_FFFF; p = x / y; return p[31:0]; end
      default: begin if (b == 0) return a; p = x % y; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic sb, input logic [31:0] b);
    logic [31:0] mag;
    mag = (sb && b[31]) ? (32'd0 - b) : b;
    if (op[1] && b == 0 && DZF) return 1;
`ifdef DR32E_MULT_EARLY_EXIT_EN
    if (!op[1]) begin
      if (mag == 0) return 2;
      for (int i = 31; i >= 0; i--) if (mag[i]) return i + 2;
    end
`endif
    return 33;
  endfunction

  // ---------------- driver ----------------
  // Called at #1 after a rising edge with the DUT in IDLE. Operands are
  // scrambled after the start edge to show they are not re-sampled.
  task automatic run_op(input logic [1:0] op, input logic sa, input logic sb,
                        input logic [31:0] a, input logic [31:0] b, input bit keep_en,
                        output logic [31:0] res, output int lat,
                        output int busy_err, output int pulse_err);
    res = 32'd0; lat = -1; busy_err = 0; pulse_err = 0;
    md_op_i = op; signed_a_i = sa; signed_b_i = sb;
    operand_a_i = a; operand_b_i = b; en_i = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        operand_a_i = $urandom; operand_b_i = $urandom;
        md_op_i = 2'($urandom_range(0, 3));
        signed_a_i = 1'($urandom_range(0, 1)); signed_b_i = 1'($urandom_range(0, 1));
      end
      if (valid_o) begin
        res = result_o; lat = cyc;
        if (busy_o) busy_err++;
        break;
      end else if (!busy_o) begin
        busy_err++;
      end
    end
    if (!keep_en) en_i = 1'b0;
    @(posedge clk); #1;
    if (valid_o) pulse_err++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy_o); else n_pass++;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b want=0", valid_o); else n_pass++;
    n_checks++; if (result_o !== 32'd0) $display("FAIL reset_result got=%h want=0", result_o); else n_pass++;
    n_checks++; if (state_o !== 2'd0) $display("FAIL reset_state got=%0d want=0", state_o); else n_pass++;
    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op[13]  = '{0, 1, 1, 2, 3, 2, 2, 3, 2, 2, 3, 0, 3};
    logic        t_sa[13]  = '{1, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 1};
    logic        t_sb[13]  = '{1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 1};
    logic [31:0] t_a[13]   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'd100, 32'h12345678, 32'h12345678, 32'h12345678, 32'h80000000,
                               32'h80000000, 32'h12345678, 32'h80000000};
    logic [31:0] t_b[13]   = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd0, 32'd0,
                               32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0};
    logic [31:0] t_exp[13] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'd14, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h80000000,
                               32'd0, 32'h12345678, 32'h80000000};
    logic [31:0] res, e;
    int lat, be, pe, el;
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(t_exp[i]);
      el = ref_latency(t_op[i], t_sb[i], t_b[i]);
      run_op(t_op[i], t_sa[i], t_sb[i], t_a[i], t_b[i], 1'b0, res, lat, be, pe);
      e = exp_q.pop_front(); last_exp = e;
      n_checks++; if (res !== e) $display("FAIL dir%0d_result got=%h want=%h", i, res, e); else n_pass++;
      n_checks++; if (lat != el) $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, el); else n_pass++;
      n_checks++; if (be != 0) $display("FAIL dir%0d_busy got=%0d bad cycles want=0", i, be); else n_pass++;
      n_checks++; if (pe != 0) $display("FAIL dir%0d_pulse got=%0d extra valid want=0", i, pe); else n_pass++;
    end
  endtask

  task automatic test_random(input int n, input bit b2b);
    logic [1:0] op; logic sa, sb; logic [31:0] a, b, res, e;
    int lat, be, pe, el, errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 15));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      exp_q.push_back(ref_result(op, sa, sb, a, b));
      el = ref_latency(op, sb, b);
      run_op(op, sa, sb, a, b, b2b && (i != n - 1), res, lat, be, pe);
      e = exp_q.pop_front(); last_exp = e;
      n_checks++;
      if (res !== e || lat != el || be != 0 || pe != 0) begin
        $display("FAIL rand%0d op=%0d sa=%0b sb=%0b a=%h b=%h got=%h lat=%0d busy_err=%0d pulse_err=%0d want=%h lat=%0d",
                 i, op, sa, sb, a, b, res, lat, be, pe, e, el);
      end else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [31:0] res, e; int lat, be, pe, seen;
    seen = 0;
    md_op_i = 2'd2; signed_a_i = 1'b1; signed_b_i = 1'b1;
    operand_a_i = 32'hFFFFFF00; operand_b_i = 32'd3; en_i = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    en_i = 1'b0;
    @(posedge clk); #1;
    if (valid_o) seen++;
    n_checks++; if (seen != 0) $display("FAIL abort_novalid got=%0d pulses want=0", seen); else n_pass++;
    n_checks++; if (state_o !== 2'd0 || busy_o !== 1'b0) $display("FAIL abort_idle got state=%0d busy=%b want 0/0", state_o, busy_o); else n_pass++;
    n_checks++; if (result_o !== last_exp) $display("FAIL abort_result_kept got=%h want=%h", result_o, last_exp); else n_pass++;
    @(posedge clk); #1;
    exp_q.push_back(ref_result(2'd3, 1'b1, 1'b1, 32'hFFFFFF00, 32'd7));
    run_op(2'd3, 1'b1, 1'b1, 32'hFFFFFF00, 32'd7, 1'b0, res, lat, be, pe);
    e = exp_q.pop_front(); last_exp = e;
    n_checks++; if (res !== e || lat != 33) $display("FAIL abort_restart got=%h lat=%0d want=%h lat=33", res, lat, e); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, e; int lat, be, pe;
    md_op_i = 2'd1; signed_a_i = 1'b0; signed_b_i = 1'b0;
    operand_a_i = 32'hDEADBEEF; operand_b_i = 32'hCAFEF00D; en_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_ni = 1'b0; en_i = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) $display("FAIL rstmid_outputs got busy=%b valid=%b want 0/0", busy_o, valid_o); else n_pass++;
    n_checks++; if (result_o !== 32'd0 || state_o !== 2'd0) $display("FAIL rstmid_state got result=%h state=%0d want 0/0", result_o, state_o); else n_pass++;
    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(ref_result(2'd1, 1'b1, 1'b1, 32'h80000000, 32'h80000000));
    run_op(2'd1, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 1'b0, res, lat, be, pe);
    e = exp_q.pop_front(); last_exp = e;
    n_checks++; if (res !== e || pe != 0) $display("FAIL rstmid_recover got=%h pulse_err=%0d want=%h", res, pe, e); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random(30, 1'b0);
    test_random(6, 1'b1);
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
